la_capture_buffer: RTL
======================

# la_capture_buffer

Trigger-qualified capture buffer sitting directly downstream of the UART byte decoder in the tiny logic analyzer. Accepts decoded bytes with a one-cycle valid strobe and keeps a rolling pre-trigger history in a circular buffer. On a masked byte-match trigger, captures a fixed number of post-trigger bytes, then freezes and serves the capture oldest-first over a simple request/valid read port.

## Interface
- `DEPTH`, 16, capture entries; power of two, ≥4.
- `AW`, 4, address width = log2(DEPTH).
- `POST_TRIG`, 8, bytes captured after the trigger byte; 0 ≤ POST_TRIG ≤ DEPTH-1.

Clocking: one clock `clk`; reset `rst_n` is asynchronous, active-low.

- `clk` in 1 system clock
- `rst_n` in 1 async active-low reset
- `in_data` in 8 decoded byte from UART decoder
- `in_valid` in 1 one-cycle strobe, `in_data` valid
- `trig_value` in 8 trigger compare value
- `trig_mask` in 8 compare mask, 1 = bit compared
- `arm` in 1 pulse: clear and start capture
- `rd_req` in 1 read request, one entry per cycle
- `rd_data` out 8 read data
- `rd_valid` out 1 `rd_data` valid (one-cycle pulse)
- `armed` out 1 high in PRE or POST
- `triggered` out 1 high in POST or DONE
- `done` out 1 high in DONE
- `count` out AW+1 entries held (0..DEPTH)

## Operation
- States: IDLE, PRE, POST, DONE. Reset → IDLE. All outputs reset to 0; `wr_ptr`, `count`, `post_cnt`, `rd_ptr` reset to 0.
- IDLE: `in_valid` ignored. `arm` → PRE, `wr_ptr`=0, `count`=0.
- PRE: each `in_valid` writes `in_data` at `wr_ptr`, `wr_ptr` += 1 mod DEPTH, `count` saturates at DEPTH (oldest overwritten).
  - Trigger when `(in_data & trig_mask) == (trig_value & trig_mask)` on a valid byte. The trigger byte is stored.
  - If POST_TRIG = 0 → DONE; else → POST with `post_cnt`=POST_TRIG.
  - `trig_mask`=0 triggers on the first valid byte.
- POST: valid bytes are stored as in PRE, and `post_cnt` decrements. The write that takes `post_cnt` to 0 → DONE. No further trigger evaluation.
- DONE: writes blocked.
  - Read pointer starts at oldest = (`wr_ptr` − `count`) mod DEPTH.
  - Each `rd_req` with `count`>0 reads one entry, advances `rd_ptr` mod DEPTH and decrements `count`.
  - `rd_req` with `count`=0 is ignored (no `rd_valid`).
  - When `count` reaches 0 → IDLE.
- `rd_req` outside DONE is ignored.
- `arm` in any state restarts into PRE, clearing `count` and pointers. `arm` has priority over same-cycle `in_valid` and `rd_req`; that byte is dropped.
- Async reset mid-capture or mid-readout returns to IDLE, discarding contents. Memory contents are not reset.
- Width rules: `count` is AW+1 bits; pointers are AW bits and wrap naturally.

## Timing
- `in_valid` in cycle n: write at edge ending n.
  - `count` updates and state change are visible in cycle n+1.
  - `triggered` rises in n+1 on the trigger byte.
- `done` rises the cycle after the final post-trigger write.
- Read latency 1: `rd_req` in cycle n → `rd_data`/`rd_valid` in n+1.
  - Back-to-back `rd_req` yields one entry per cycle.
  - The last `rd_valid` coincides with state = IDLE and `done`=0.
- `rd_data` holds its last value when `rd_valid`=0.
- `in_valid` is always a single-cycle strobe from the decoder. No backpressure; bytes arriving in IDLE/DONE are lost by design.

## Structure
- Shared package `la_pkg`: state typedef (IDLE/PRE/POST/DONE), default DEPTH/POST_TRIG constants, byte type.
- Sub-module `la_capture_ram`: DEPTH×8 register file, one synchronous write port, one synchronous read port with registered output. No reset on storage.
- Top holds the FSM, pointers, counters and trigger compare.

## Test plan
- Reset, then `arm`; send 0x01..0x05 with trigger 0xA5/mask 0xFF, then 0xA5, then 8 bytes 0x10..0x17 → `done`, `count`=14. Reading yields 0x01..0x05, 0xA5, 0x10..0x17, then IDLE.
- Wrap: send 40 non-matching bytes 0x00..0x27, then trigger 0xA5 plus 8 post bytes → `count`=16. Read order starts 0x21 (7 history bytes 0x21..0x27, 0xA5, 8 post).
- Mask: trig_value 0xF0, mask 0xF0; send 0x3F, 0xF7 → trigger on 0xF7, `triggered` high the next cycle.
- POST_TRIG=0 build: trigger byte → `done` the next cycle; further `in_valid` does not change `count`.
- `arm` asserted with `in_valid` and during readout → state PRE, `count`=0, the byte dropped, no `rd_valid`.
- `rst_n` low mid-POST → all outputs 0, IDLE; `rd_req` afterwards gives no `rd_valid`.

Source files
------------

// File: rtl/la_pkg.sv
// Shared definitions for the logic-analyzer capture path.
//   la_state_e       : capture FSM state encoding
//   LA_*_DEF         : default build constants
//   la_byte_t        : decoded byte type
//   la_trig_hit()    : masked byte-match compare (mask bit 1 = bit compared)
package la_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PRE  = 2'd1,
      ST_POST = 2'd2,
      ST_DONE = 2'd3
   } la_state_e;

   localparam int LA_DEPTH_DEF     = 16;
   localparam int LA_AW_DEF        = 4;
   localparam int LA_POST_TRIG_DEF = 8;

   typedef logic [7:0] la_byte_t;

   function automatic logic la_trig_hit(input la_byte_t data,
                                        input la_byte_t value,
                                        input la_byte_t mask);
      return ((data ^ value) & mask) == 8'h00;
   endfunction

endpackage

// File: rtl/la_capture_ram.sv
// DEPTH x 8 capture storage: one synchronous write port, one synchronous read
// port with a registered output that holds its value between reads.
// Ports:
//   clk, rst_n          : clock, async active-low reset (output register only)
//   wr_en/wr_addr/wr_data : write port
//   rd_en/rd_addr       : read request, data appears on rd_data next cycle
//   rd_data             : registered read data
module la_capture_ram
   import la_pkg::*;
#(
   parameter int DEPTH = LA_DEPTH_DEF,
   parameter int AW    = LA_AW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [7:0]    wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [7:0]    rd_data
);

   la_byte_t mem_q [DEPTH];
   la_byte_t rd_data_d;
   la_byte_t rd_data_q;

   // Storage is deliberately not reset; only valid entries are ever read.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = mem_q[rd_addr];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else begin
         rd_data_q <= rd_data_d;
      end
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/la_capture_buffer.sv
// Trigger-qualified capture buffer behind the UART byte decoder. Keeps a
// rolling pre-trigger history, captures POST_TRIG bytes after a masked
// byte-match trigger, then freezes and serves the capture oldest-first.
// Ports:
//   clk, rst_n            : clock, async active-low reset
//   in_data, in_valid     : decoded byte and its one-cycle strobe
//   trig_value, trig_mask : trigger compare value and mask (1 = compared)
//   arm                   : clear and restart capture (highest priority)
//   rd_req                : read one entry (accepted only in DONE with data)
//   rd_data, rd_valid     : read result, one cycle after rd_req
//   armed, triggered, done: status (PRE|POST, POST|DONE, DONE)
//   count                 : entries held, 0..DEPTH
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no capture; input bytes and reads ignored
// PRE   | storing rolling history, evaluating trigger on each byte
// POST  | trigger seen, storing post_cnt remaining bytes
// DONE  | frozen; serving entries oldest-first until count reaches 0
module la_capture_buffer
   import la_pkg::*;
#(
   parameter int DEPTH     = LA_DEPTH_DEF,
   parameter int AW        = LA_AW_DEF,
   parameter int POST_TRIG = LA_POST_TRIG_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [7:0]    in_data,
   input  logic          in_valid,
   input  logic [7:0]    trig_value,
   input  logic [7:0]    trig_mask,
   input  logic          arm,
   input  logic          rd_req,
   output logic [7:0]    rd_data,
   output logic          rd_valid,
   output logic          armed,
   output logic          triggered,
   output logic          done,
   output logic [AW:0]   count
);

   localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] POST_INIT = AW'(POST_TRIG);

   la_state_e     state_d, state_q;
   logic [AW-1:0] wr_ptr_d, wr_ptr_q;
   logic [AW-1:0] rd_ptr_d, rd_ptr_q;
   logic [AW-1:0] post_cnt_d, post_cnt_q;
   logic [AW:0]   count_d, count_q;
   logic          rd_valid_d, rd_valid_q;
   logic          wr_en;
   logic          rd_en;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      post_cnt_d = post_cnt_q;
      count_d    = count_q;
      wr_en      = 1'b0;
      rd_en      = 1'b0;

      if (arm) begin
         // arm wins over a same-cycle byte or read; that byte is dropped
         state_d    = ST_PRE;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         post_cnt_d = '0;
         count_d    = '0;
      end else begin
         case (state_q)
            ST_PRE, ST_POST: begin
               if (in_valid) begin
                  wr_en    = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  count_d  = (count_q == CNT_FULL) ? count_q : count_q + (AW+1)'(1);
                  if (state_q == ST_PRE) begin
                     if (la_trig_hit(in_data, trig_value, trig_mask)) begin
                        if (POST_TRIG == 0) begin
                           state_d = ST_DONE;
                        end else begin
                           state_d    = ST_POST;
                           post_cnt_d = POST_INIT;
                        end
                     end
                  end else begin
                     post_cnt_d = post_cnt_q - AW'(1);
                     if (post_cnt_q == AW'(1)) begin
                        state_d = ST_DONE;
                     end
                  end
                  // Oldest entry; a full buffer yields wr_ptr itself since count[AW-1:0] is 0.
                  if (state_d == ST_DONE) begin
                     rd_ptr_d = wr_ptr_d - count_d[AW-1:0];
                  end
               end
            end
            ST_DONE: begin
               if (rd_req && (count_q != '0)) begin
                  rd_en    = 1'b1;
                  rd_ptr_d = rd_ptr_q + AW'(1);
                  count_d  = count_q - (AW+1)'(1);
                  if (count_q == (AW+1)'(1)) begin
                     state_d = ST_IDLE;
                  end
               end
            end
            default: begin
               state_d = state_q;
            end
         endcase
      end
   end

   assign rd_valid_d = rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         post_cnt_q <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         post_cnt_q <= post_cnt_d;
         count_q    <= count_d;
         rd_valid_q <= rd_valid_d;
      end
   end

   la_capture_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (wr_en),
      .wr_addr (wr_ptr_q),
      .wr_data (in_data),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr_q),
      .rd_data (rd_data)
   );

   assign rd_valid  = rd_valid_q;
   assign armed     = (state_q == ST_PRE)  || (state_q == ST_POST);
   assign triggered = (state_q == ST_POST) || (state_q == ST_DONE);
   assign done      = (state_q == ST_DONE);
   assign count     = count_q;

endmodule
